float_to_fixed_param: RTL and testbench

Parametrised successor to the single-format float-to-fixed converter. Converts an IEEE-754 single-precision word into a signed two's-complement fixed-point value with a configurable total width and fraction width. Adds selectable rounding, saturation and invalid-input flagging, all under a Begin/ACK handshake. It sits between the floating-point datapath and the fixed-point (CORDIC/vector) stages.

---
 rtl/float_fixed_pkg.sv | 27 ++
 rtl/fixed_round_shift.sv | 53 +++++
 rtl/float_to_fixed_param.sv | 171 +++++++++++++++++
 tb/tb_float_to_fixed_param.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/float_fixed_pkg.sv
// Shared definitions for the parametrised float-to-fixed converter:
// FSM state encoding, IEEE-754 single-precision constants and the
// saturation-limit helper.
package float_fixed_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 24;
  localparam int EXP_MAX  = 255;

  // Magnitude limit for a W-bit two's-complement result, held in 65 bits so
  // it can be compared against the (W+1)-bit magnitude for any legal W.
  // neg=0: 2^(W-1)-1 ; neg=1: 2^(W-1)
  function automatic logic [64:0] sat_limit(input int w, input logic neg);
    logic [64:0] one;
    one = 65'd1;
    return neg ? (one << (w - 1)) : ((one << (w - 1)) - 65'd1);
  endfunction

endpackage

// File: rtl/fixed_round_shift.sv
// Combinational bidirectional shifter (magnitude, guard, sticky) and the
// round-to-nearest-even incrementer used by float_to_fixed_param.
module fixed_round_shift
  import float_fixed_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [MANT_W-1:0] mant_i,
  input  logic signed [10:0] shift_i,
  output logic [W:0]         mag_o,
  output logic               guard_o,
  output logic               sticky_o,
  input  logic               rnd_i,
  input  logic [W:0]         rmag_i,
  input  logic               rguard_i,
  input  logic               rsticky_i,
  output logic [W:0]         rmag_o
);

  logic [W+MANT_W:0] wide;
  logic [49:0]       ext;
  logic [10:0]       amt;

  // Shift the 24-bit significand left (k>=0) or right (k<0) into a W+1 bit
  // magnitude; right shifts also report the guard bit and sticky OR.
  always_comb begin
    mag_o    = '0;
    guard_o  = 1'b0;
    sticky_o = 1'b0;
    wide     = '0;
    ext      = '0;
    amt      = -shift_i;
    if (!shift_i[10]) begin
      wide  = {{(W+1){1'b0}}, mant_i} << shift_i[9:0];
      mag_o = wide[W:0];
    end else if (amt > 11'd25) begin
      // Everything shifted out; the significand is nonzero so sticky is set.
      sticky_o = 1'b1;
    end else begin
      ext      = {mant_i, 26'b0} >> amt[4:0];
      wide     = {{(W+1){1'b0}}, ext[49:26]};
      mag_o    = wide[W:0];
      guard_o  = ext[25];
      sticky_o = |ext[24:0];
    end
  end

  // Ties-to-even: bump only when above half, or exactly half with odd LSB.
  always_comb begin
    rmag_o = rmag_i + (W+1)'(rnd_i & rguard_i & (rsticky_i | rmag_i[0]));
  end

endmodule

// File: rtl/float_to_fixed_param.sv
// IEEE-754 single-precision to signed fixed-point (W bits, FRAC fraction
// bits) converter with selectable rounding, saturation and NaN/Inf flagging,
// driven by a Begin/ACK handshake through a five-state FSM.
module float_to_fixed_param
  import float_fixed_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 26
) (
  input  logic         CLK,
  input  logic         RST_FF,
  input  logic         Begin_FSM_FF,
  input  logic [31:0]  F,
  input  logic         RND_MODE,
  output logic         ACK_FF,
  output logic         BUSY,
  output logic [W-1:0] RESULT,
  output logic         OVF,
  output logic         INV
);

  localparam logic signed [10:0] K_OFS   = 11'(FRAC - EXP_BIAS - (MANT_W - 1));
  localparam logic signed [10:0] K_MAX   = 11'(W - MANT_W);
  localparam logic [64:0]        POS_LIM = sat_limit(W, 1'b0);
  localparam logic [64:0]        NEG_LIM = sat_limit(W, 1'b1);
  localparam logic [W-1:0]       POS_SAT = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]       NEG_SAT = {1'b1, {(W-1){1'b0}}};

  state_e state_q, state_d;

  logic [31:0]         f_q;
  logic                rnd_q;
  logic                s_q, zero_q, nan_q, inf_q, eovf_q;
  logic [MANT_W-1:0]   mant_q;
  logic signed [10:0]  k_q;
  logic [W:0]          mag_q, rmag_q;
  logic                guard_q, sticky_q, rovf_q;
  logic [W-1:0]        result_q;
  logic                ovf_q, inv_q, ack_q;

  logic [7:0]          exp_w;
  logic [22:0]         frac_w;
  logic signed [10:0]  k_d;
  logic                eovf_d;
  logic [W:0]          mag_w, rmag_w;
  logic                guard_w, sticky_w, rovf_d;
  logic [64:0]         rmag_ext;
  logic                normal_w, sat_w;
  logic [W-1:0]        mag_lo, result_d;

  fixed_round_shift #(.W(W)) u_shift (
    .mant_i   (mant_q),
    .shift_i  (k_q),
    .mag_o    (mag_w),
    .guard_o  (guard_w),
    .sticky_o (sticky_w),
    .rnd_i    (rnd_q),
    .rmag_i   (mag_q),
    .rguard_i (guard_q),
    .rsticky_i(sticky_q),
    .rmag_o   (rmag_w)
  );

  // Operand decode, early-overflow test and post-round range test.
  always_comb begin
    exp_w    = f_q[30:23];
    frac_w   = f_q[22:0];
    k_d      = $signed({3'b000, exp_w}) + K_OFS;
    eovf_d   = (k_d > K_MAX) ||
               ((k_d == K_MAX) && !(f_q[31] && (frac_w == 23'd0)));
    rmag_ext = 65'(rmag_w);
    rovf_d   = s_q ? (rmag_ext > NEG_LIM) : (rmag_ext > POS_LIM);
  end

  // Final result selection: saturate, flush/NaN to zero, or signed magnitude.
  always_comb begin
    normal_w = !zero_q && !nan_q && !inf_q;
    sat_w    = inf_q || (normal_w && (eovf_q || rovf_q));
    mag_lo   = rmag_q[W-1:0];
    if (sat_w)                result_d = s_q ? NEG_SAT : POS_SAT;
    else if (zero_q || nan_q) result_d = '0;
    else if (s_q)             result_d = -mag_lo;
    else                      result_d = mag_lo;
  end

  // State register.
  always_ff @(posedge CLK or posedge RST_FF) begin
    if (RST_FF) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: a fixed walk through the conversion steps.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (Begin_FSM_FF) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: state_d = ST_ROUND;
      ST_ROUND: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    BUSY   = (state_q != ST_IDLE);
    ACK_FF = ack_q;
    RESULT = result_q;
    OVF    = ovf_q;
    INV    = inv_q;
  end

  // Operand capture and per-step datapath registers; reset discards any
  // conversion in flight.
  always_ff @(posedge CLK or posedge RST_FF) begin
    if (RST_FF) begin
      f_q      <= '0;
      rnd_q    <= 1'b0;
      s_q      <= 1'b0;
      zero_q   <= 1'b0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      eovf_q   <= 1'b0;
      mant_q   <= '0;
      k_q      <= '0;
      mag_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      rmag_q   <= '0;
      rovf_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= (state_q == ST_DONE);
      unique case (state_q)
        ST_IDLE: if (Begin_FSM_FF) begin
          f_q   <= F;
          rnd_q <= RND_MODE;
        end
        ST_LOAD: begin
          s_q    <= f_q[31];
          zero_q <= (exp_w == 8'd0);
          nan_q  <= (exp_w == 8'(EXP_MAX)) && (frac_w != 23'd0);
          inf_q  <= (exp_w == 8'(EXP_MAX)) && (frac_w == 23'd0);
          eovf_q <= eovf_d;
          mant_q <= {exp_w != 8'd0, frac_w};
          k_q    <= k_d;
        end
        ST_SHIFT: begin
          mag_q    <= mag_w;
          guard_q  <= guard_w;
          sticky_q <= sticky_w;
        end
        ST_ROUND: begin
          rmag_q <= rmag_w;
          rovf_q <= rovf_d;
        end
        ST_DONE: begin
          result_q <= result_d;
          ovf_q    <= sat_w;
          inv_q    <= nan_q || inf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_fixed_param.sv
// Scoreboard bench for float_to_fixed_param (W=32, FRAC=26): stimulus pushes
// hand-computed expectations, an independent monitor pops on every ACK.
module tb_float_to_fixed_param;

  logic        CLK = 1'b0;
  logic        RST_FF = 1'b1;
  logic        Begin_FSM_FF = 1'b0;
  logic [31:0] F = '0;
  logic        RND_MODE = 1'b0;
  logic        ACK_FF, BUSY, OVF, INV;
  logic [31:0] RESULT;

  typedef struct packed {
    logic [31:0] r;
    logic        o;
    logic        i;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  float_to_fixed_param #(.W(32), .FRAC(26)) dut (
    .CLK         (CLK),
    .RST_FF      (RST_FF),
    .Begin_FSM_FF(Begin_FSM_FF),
    .F           (F),
    .RND_MODE    (RND_MODE),
    .ACK_FF      (ACK_FF),
    .BUSY        (BUSY),
    .RESULT      (RESULT),
    .OVF         (OVF),
    .INV         (INV)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ACK must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (ACK_FF === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ACK with RESULT 0x%0h, expected no ACK", RESULT);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", {32'd0, RESULT}, {32'd0, mon_e.r});
        chk("ovf", {63'd0, OVF}, {63'd0, mon_e.o});
        chk("inv", {63'd0, INV}, {63'd0, mon_e.i});
      end
    end
  end

  // Wait for ACK with a bound; returns cycles counted and BUSY-high cycles.
  task automatic wait_ack(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      lat++;
      if (BUSY) busy_cnt++;
      if (ACK_FF) return;
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout: got no ACK in %0d cycles, expected ACK", lat);
  endtask

  task automatic convert(input logic [31:0] f, input logic rnd, input logic [31:0] r,
                         input logic o, input logic i, input bit chk_lat);
    int lat, bc;
    @(negedge CLK);
    F = f;
    RND_MODE = rnd;
    Begin_FSM_FF = 1'b1;
    exp_q.push_back('{r: r, o: o, i: i});
    @(posedge CLK);
    #1 Begin_FSM_FF = 1'b0;
    wait_ack(lat, bc);
    if (chk_lat) begin
      chk("latency", 64'(lat), 64'd5);
      chk("busy_cycles", 64'(bc), 64'd4);
    end
  endtask

  initial begin
    int lat, bc;
    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_ack", {63'd0, ACK_FF}, 64'd0);
    chk("rst_busy", {63'd0, BUSY}, 64'd0);
    chk("rst_result", {32'd0, RESULT}, 64'd0);
    chk("rst_flags", {62'd0, OVF, INV}, 64'd0);
    RST_FF = 1'b0;

    // Directed vectors
    convert(32'h3F800000, 1'b0, 32'h04000000, 1'b0, 1'b0, 1'b1); // 1.0
    convert(32'hC0200000, 1'b0, 32'hF6000000, 1'b0, 1'b0, 1'b0); // -2.5
    convert(32'h42200000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0); // 40.0 overflow
    convert(32'hC2000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0); // -32.0 exact limit
    convert(32'h41FC0000, 1'b0, 32'h7E000000, 1'b0, 1'b0, 1'b0); // 31.5
    convert(32'h32C00000, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0); // 1.5 LSB RNE
    convert(32'h32C00000, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0); // 1.5 LSB trunc
    convert(32'h32000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0); // 0.5 LSB tie to even
    convert(32'h32400000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0); // 0.75 LSB RNE
    convert(32'hB2C00000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0); // -1.5 LSB RNE
    convert(32'h2F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0); // far below LSB
    convert(32'h7FC00000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0); // NaN
    convert(32'hFF800000, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0); // -Inf
    convert(32'h7F800000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0); // +Inf
    convert(32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0); // denormal
    convert(32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0); // -0

    // Begin re-pulsed during SHIFT with a different operand: ignored
    @(negedge CLK);
    F = 32'h3F800000;
    RND_MODE = 1'b0;
    Begin_FSM_FF = 1'b1;
    exp_q.push_back('{r: 32'h04000000, o: 1'b0, i: 1'b0});
    @(posedge CLK);
    #1 Begin_FSM_FF = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    F = 32'h42200000;
    Begin_FSM_FF = 1'b1;
    @(posedge CLK);
    #1 Begin_FSM_FF = 1'b0;
    wait_ack(lat, bc);
    repeat (8) @(negedge CLK);
    chk("repulse_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while in ROUND
    @(negedge CLK);
    F = 32'hC0200000;
    Begin_FSM_FF = 1'b1;
    exp_q.push_back('{r: 32'hF6000000, o: 1'b0, i: 1'b0});
    @(posedge CLK);
    #1 Begin_FSM_FF = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #3 RST_FF = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_ack", {63'd0, ACK_FF}, 64'd0);
    chk("mid_rst_busy", {63'd0, BUSY}, 64'd0);
    chk("mid_rst_result", {32'd0, RESULT}, 64'd0);
    chk("mid_rst_flags", {62'd0, OVF, INV}, 64'd0);
    @(negedge CLK);
    RST_FF = 1'b0;
    repeat (8) @(negedge CLK);
    chk("post_rst_idle", {63'd0, BUSY}, 64'd0);

    convert(32'h3F800000, 1'b0, 32'h04000000, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge CLK);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
